// File: rtl/risc_v_pkg.sv
// Shared definitions for the memory-port arbiter: data width, default
// starvation limit and the arbiter state encoding.
package risc_v_pkg;

    localparam int XLEN                 = 32;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // Width of the starvation counter: at least 3 bits, wider if the limit needs it.
    function automatic int starve_cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single shared memory port between the fetch stage and the
// memory stage. One transfer is outstanding at a time; data accesses win
// unless fetch has waited through STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
    import risc_v_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ack,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_ack,
    output logic            mem_valid,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_if,
    output logic            stall_mem
);

    localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t      state_q, state_d;
    logic            mem_valid_q, mem_valid_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            if_ack_q, if_ack_d;
    logic            dm_ack_q, dm_ack_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    // Goes high on the first edge after reset release; grants wait for it so
    // the earliest grant lands on the second edge.
    logic            rst_done_q, rst_done_d;

    // Next-state, grant decision, starvation counter and response capture.
    always_comb begin
        state_d      = state_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        starve_cnt_d = starve_cnt_q;
        rst_done_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (!rst_done_q) begin
                    mem_valid_d = 1'b0;
                end else if (dm_req && !(if_req && (starve_cnt_q == LIMIT))) begin
                    state_d     = BUSY_DM;
                    mem_valid_d = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_req) begin
                        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT
                                                               : starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        starve_cnt_d = {CNT_W{1'b0}};
                    end
                end else if (if_req) begin
                    state_d      = BUSY_IF;
                    mem_valid_d  = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = {XLEN{1'b0}};
                    starve_cnt_d = {CNT_W{1'b0}};
                end else begin
                    mem_valid_d  = 1'b0;
                    starve_cnt_d = {CNT_W{1'b0}};
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    if_rdata_d  = mem_rdata;
                    if_ack_d    = 1'b1;
                end else begin
                    mem_valid_d = 1'b1;
                end
            end
            BUSY_DM: begin
                if (mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    dm_ack_d    = 1'b1;
                    // Stores return nothing; keep the last load data.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    mem_valid_d = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {XLEN{1'b0}};
            mem_wdata_q  <= {XLEN{1'b0}};
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= {XLEN{1'b0}};
            dm_rdata_q   <= {XLEN{1'b0}};
            starve_cnt_q <= {CNT_W{1'b0}};
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            starve_cnt_q <= starve_cnt_d;
            rst_done_q   <= rst_done_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stall a stage while its request is pending and not yet acknowledged.
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while a fetch waits.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 if_req  in  1  fetch-stage request, held high until if_ack.
REQ-005 if_addr  in  32  fetch address, stable while if_req high.
REQ-006 if_rdata  out  32  fetch read data, valid only while if_ack high.
REQ-007 if_ack  out  1  one-cycle fetch completion pulse.
REQ-008 dm_req  in  1  memory-stage request, held high until dm_ack.
REQ-009 dm_we  in  1  1 = store, 0 = load; stable while dm_req high.
REQ-010 dm_addr / dm_wdata  in  32 / 32  data address / store data, stable while dm_req high.
REQ-011 dm_rdata  out  32  load data, valid only while dm_ack high.
REQ-012 dm_ack  out  1  one-cycle data completion pulse.
REQ-013 mem_valid / mem_we  out  1 / 1  shared-port request and write strobe, registered.
REQ-014 mem_addr / mem_wdata  out  32 / 32  shared-port address and write data, registered.
REQ-015 mem_ready  in  1  port accepts/completes the transfer in the cycle it is high with mem_valid.
REQ-016 mem_rdata  in  32  port read data, valid with mem_ready.
REQ-017 stall_if / stall_mem  out  1 / 1  pipeline stall requests to fetch / memory stages.

Function
REQ-018 FSM states: IDLE, BUSY_IF, BUSY_DM, RESP; exactly one transfer outstanding at a time.
REQ-019 IDLE, no request: stay IDLE, mem_valid 0.
REQ-020 IDLE, requests present: grant dm unless starve_cnt == STARVE_LIMIT and if_req high, then grant if; lone requester always granted.
REQ-021 Grant edge: register granted addr/wdata/we into mem_* and set mem_valid 1; go BUSY_IF or BUSY_DM (mem_valid high one cycle after req sampled).
REQ-022 BUSY_x: hold mem_* stable and mem_valid 1 until mem_ready; no wait-state limit.
REQ-023 BUSY_x with mem_ready: capture mem_rdata, clear mem_valid, go RESP; if_ack/dm_ack and rdata valid in RESP cycle (ack one cycle after mem_ready).
REQ-024 RESP: exactly one ack (matching granted requester) high; no new grant; next state IDLE unconditionally.
REQ-025 Minimum request-to-request spacing: mem_valid deasserted for at least one RESP and one IDLE cycle between transfers.
REQ-026 if_rdata/dm_rdata hold last captured value outside ack; checkers consider them only with ack.
REQ-027 starve_cnt (3 bits min, saturating at STARVE_LIMIT): +1 on each dm grant while if_req high; cleared on if grant or when if_req low in IDLE.
REQ-028 stall_if = if_req & ~if_ack; stall_mem = dm_req & ~dm_ack; combinational.
REQ-029 Store transfers: mem_rdata ignored; dm_ack still pulses in RESP.
REQ-030 Request dropped before grant: no transfer issued; request dropped mid-BUSY is protocol violation, transfer still completes and acks.

Reset
REQ-031 reset low: state IDLE, mem_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, if_ack 0, dm_ack 0, if_rdata 0, dm_rdata 0, starve_cnt 0, asynchronously.
REQ-032 Reset mid-BUSY abandons transfer with no ack; first grant possible on second rising edge after reset release.

Structure
REQ-033 Shared package risc_v_pkg holds arbiter state enum (arb_state_t), XLEN = 32, STARVE_LIMIT default constant.
REQ-034 Single module, no sub-module; FSM, starvation counter, output registers in one file.

Verification
REQ-035 Lone fetch: if_req=1, if_addr=0x100, mem_ready=1 two cycles later, mem_rdata=0x00500093 -> mem_addr=0x100, if_ack one cycle, if_rdata=0x00500093, stall_if low after ack.
REQ-036 Simultaneous req: if_req and dm_req (load 0x2000) in same cycle -> dm granted first, if granted after dm RESP; stall_if high throughout.
REQ-037 Starvation: dm_req continuously high with 5 back-to-back loads, if_req high -> 4 dm grants, then if grant, then dm resumes.
REQ-038 Store with 3 wait states: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ready low 3 cycles -> mem_* stable 4 cycles, mem_we=1, dm_ack one pulse.
REQ-039 Reset mid-transfer: reset low during BUSY_DM -> mem_valid 0 same cycle, no dm_ack, all outputs zero; after release fresh if_req served normally.
